// File: rtl/bcd_sub_serial_pkg.sv
// -----------------------------------------------------------------------------
// bcd_sub_serial_pkg
// Shared decimal-arithmetic definitions for the serial BCD subtractor and its
// digit slice.
//   state_t      : controller states (IDLE, RUN, DONE)
//   BCD_RADIX    : decimal radix, used for the negative-digit correction
//   bcd_digit_t  : one packed BCD digit
//   bcd_invalid  : a 4-bit code that is not a decimal digit (> 9)
// -----------------------------------------------------------------------------
package bcd_sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_RADIX = 10;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic bcd_invalid(input bcd_digit_t d);
        return d > bcd_digit_t'(BCD_RADIX - 1);
    endfunction

endpackage

// File: rtl/bcd_sub_digit.sv
// -----------------------------------------------------------------------------
// bcd_sub_digit
// Combinational single-digit BCD subtract slice: a_d - b_d - br.
//   a_d    in  4  minuend digit
//   b_d    in  4  subtrahend digit
//   br     in  1  incoming borrow
//   digit  out 4  result digit (ten's-complement corrected when negative)
//   br_out out 1  borrow to the next more-significant digit
//   bad    out 1  a_d or b_d is not a valid decimal digit
// -----------------------------------------------------------------------------
module bcd_sub_digit
    import bcd_sub_serial_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       br,
    output logic [3:0] digit,
    output logic       br_out,
    output logic       bad
);

    // 5-bit two's-complement difference. Range is -16..15, so bit 4 is the
    // sign and the low nibble is t mod 16 in either case.
    logic [4:0] t;

    assign t      = {1'b0, a_d} - {1'b0, b_d} - {4'b0000, br};
    assign br_out = t[4];

    // Negative: add the radix back; the 4-bit sum wraps, giving (t+10) mod 16.
    assign digit  = br_out ? (t[3:0] + 4'(BCD_RADIX)) : t[3:0];

    assign bad    = bcd_invalid(a_d) | bcd_invalid(b_d);

endmodule

// File: rtl/bcd_sub_serial.sv
// -----------------------------------------------------------------------------
// bcd_sub_serial
// Digit-serial BCD subtractor: diff = (10^DIGITS + A - B - bin) mod 10^DIGITS,
// one digit per clock, least-significant digit first.
//   DIGITS     param   number of packed BCD digits per operand (>= 1)
//   clk        in  1   rising-edge clock
//   rst        in  1   asynchronous active-high reset
//   in_valid   in  1   operand bundle valid
//   in_ready   out 1   operands accepted (high only in IDLE)
//   a, b       in  4*DIGITS  minuend / subtrahend, digit i at [4i+3:4i]
//   bin        in  1   borrow-in applied at digit 0
//   out_valid  out 1   result valid (high only in DONE)
//   out_ready  in  1   consumer takes the result
//   diff       out 4*DIGITS  packed BCD difference
//   bout       out 1   borrow-out (A - B - bin < 0)
//   err        out 1   some input digit of a or b was > 9
// Sequence: IDLE -accept-> RUN (DIGITS cycles) -> DONE -out_ready-> IDLE.
// -----------------------------------------------------------------------------
module bcd_sub_serial
    import bcd_sub_serial_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] diff,
    output logic                bout,
    output logic                err
);

    localparam int              IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    state_t                state;
    logic [4*DIGITS-1:0]   a_q;
    logic [4*DIGITS-1:0]   b_q;
    logic                  br;
    logic [IDXW-1:0]       idx;

    // Digit currently being processed, selected from the captured operands.
    bcd_digit_t            a_cur;
    bcd_digit_t            b_cur;
    bcd_digit_t            d_cur;
    logic                  br_nxt;
    logic                  d_bad;

    // Per-digit validity of the live inputs, folded into err at accept.
    logic [DIGITS-1:0]     in_bad;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_in_chk
            assign in_bad[g] = bcd_invalid(a[4*g +: 4]) | bcd_invalid(b[4*g +: 4]);
        end
    endgenerate

    assign a_cur = a_q[4*idx +: 4];
    assign b_cur = b_q[4*idx +: 4];

    bcd_sub_digit u_digit (
        .a_d    (a_cur),
        .b_d    (b_cur),
        .br     (br),
        .digit  (d_cur),
        .br_out (br_nxt),
        .bad    (d_bad)
    );

    // Single controller: state, handshake flags and the result registers are
    // all updated here so every output is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            br        <= 1'b0;
            idx       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the input handshake here.
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        br       <= bin;
                        idx      <= '0;
                        diff     <= '0;
                        err      <= |in_bad;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    diff[4*idx +: 4] <= d_cur;
                    br               <= br_nxt;
                    // The slice sees the same digits checked at accept, so
                    // this only keeps err consistent with what was processed.
                    err              <= err | d_bad;
                    if (idx == LAST_IDX) begin
                        bout      <= br_nxt;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    // Result registers hold until the next accept.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// -----------------------------------------------------------------------------
// tb_bcd_sub_serial
// Scoreboard bench for bcd_sub_serial (DIGITS=2). The driver pushes the
// expected result of each accepted operand bundle; a monitor pops and compares
// whenever the DUT presents a result.
// -----------------------------------------------------------------------------
module tb_bcd_sub_serial;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;
    logic         err;

    bcd_sub_serial #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         err;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain decimal arithmetic when every digit is decimal; for
    // non-decimal codes, the digit-by-digit borrow rule with 4-bit results.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        int   ad, bd, t, br, d;
        int   va = 0;
        int   vb = 0;
        int   p  = 1;
        bit   bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            ad = int'(av[4*i +: 4]);
            bd = int'(bv[4*i +: 4]);
            if (ad > 9 || bd > 9) bad = 1'b1;
            va += ad * p;
            vb += bd * p;
            p  *= 10;
        end
        e.err  = bad;
        e.acc  = 0;
        e.diff = '0;
        if (!bad) begin
            e.bout = (va - vb - int'(bi)) < 0;
            d = (p + va - vb - int'(bi)) % p;
            for (int i = 0; i < DIGITS; i++) begin
                e.diff[4*i +: 4] = 4'(d % 10);
                d = d / 10;
            end
        end else begin
            br = int'(bi);
            for (int i = 0; i < DIGITS; i++) begin
                t = int'(av[4*i +: 4]) - int'(bv[4*i +: 4]) - br;
                if (t < 0) begin
                    t  = t + 10;
                    br = 1;
                end else begin
                    br = 0;
                end
                e.diff[4*i +: 4] = 4'(t & 15);
            end
            e.bout = br[0];
        end
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", n);
        end else begin
            e     = model(av, bv, bi);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble the inputs so a DUT reading them live is caught.
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++)
            v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_diff"},      32'(diff),      32'd0);
        chk({tag, "_bout"},      32'(bout),      32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        bit pv  = 1'b0;
        bit ptx = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pv  = 1'b0;
                ptx = 1'b0;
                continue;
            end
            if (ptx) begin
                chk("in_ready_after_tx",  32'(in_ready),  32'd1);
                chk("out_valid_after_tx", 32'(out_valid), 32'd0);
            end
            ptx = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: out_valid=1 diff=%0h, required no result", diff);
                end else begin
                    if (!pv) chk("latency", 32'(cyc - sb[0].acc), 32'(DIGITS));
                    chk("diff",          32'(diff),     32'(sb[0].diff));
                    chk("bout",          32'(bout),     32'(sb[0].bout));
                    chk("err",           32'(err),      32'(sb[0].err));
                    chk("in_ready_busy", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        ptx = 1'b1;
                    end
                end
            end
            pv = out_valid && !out_ready;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_vals("post_reset");

        // Basic subtraction, borrow-out, borrow-in wrap, and self-subtract.
        issue(8'h42, 8'h17, 1'b0); drain();
        issue(8'h17, 8'h42, 1'b0); drain();
        issue(8'h00, 8'h00, 1'b1);
        issue(8'h99, 8'h99, 1'b0); drain();

        // Backpressure: result held for 5 cycles, second op waits.
        out_ready = 1'b0;
        fork
            begin
                issue(8'h50, 8'h05, 1'b0);
                issue(8'h11, 8'h01, 1'b0);
            end
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the first RUN cycle: nothing may come out.
        issue(8'h77, 8'h11, 1'b0);
        rst = 1'b1;
        #2;
        chk_reset_vals("mid_run_reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(8'h31, 8'h12, 1'b0); drain();

        // Non-decimal digit.
        issue(8'h3A, 8'h01, 1'b0); drain();

        // Randomized operands with random consumer stalls.
        rand_bp = 1'b1;
        fork
            begin
                while (rand_bp) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        repeat (60) issue(rand_bcd(), rand_bcd(), 1'($urandom));
        rand_bp = 1'b0;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
